pc_stack_n2t: RTL

Parametrised program counter with a hardware return-address stack. It is the next step up from the 1-bit load register. It holds a WIDTH-bit address and supports load, increment, call (push return address and jump) and return (pop and jump). It sits between the instruction fetch path and the instruction ROM address input, and reports stack full/empty and sticky error flags.

---
 rtl/pc_stack_n2t.sv | 104 ++++++++++
 1 files changed

// File: rtl/pc_stack_n2t.sv
// pc_stack_n2t: program counter with return-address stack; optional PC_STACK_TRAP_EN jumps to TRAP_VEC on stack errors
module pc_stack_n2t #(
    parameter int                 WIDTH     = 16,
    parameter int                 DEPTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VEC = '0
`ifdef PC_STACK_TRAP_EN
    ,
    parameter logic [WIDTH-1:0]   TRAP_VEC  = WIDTH'(16'h7FF0)
`endif
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH-1:0]             in_i,
    input  logic                         load_i,
    input  logic                         inc_i,
    input  logic                         call_i,
    input  logic                         ret_i,
    input  logic                         clr_err_i,
    output logic [WIDTH-1:0]             out_o,
    output logic [$clog2(DEPTH+1)-1:0]   sp_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         overflow_o,
    output logic                         underflow_o
);
    localparam int SPW = $clog2(DEPTH+1);
    localparam int AW  = $clog2(DEPTH);

    logic [WIDTH-1:0] out_q, out_d, err_out, ret_addr;
    logic [SPW-1:0]   sp_q, sp_d;
    logic             ovf_q, ovf_d, unf_q, unf_d, push;
    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [AW-1:0]    wr_idx, rd_idx;

    assign full_o      = sp_q == SPW'(DEPTH);
    assign empty_o     = sp_q == '0;
    assign out_o       = out_q;
    assign sp_o        = sp_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;
    assign ret_addr    = out_q + 1'b1;
    assign wr_idx      = sp_q[AW-1:0];
    assign rd_idx      = AW'(sp_q - 1'b1);
`ifdef PC_STACK_TRAP_EN
    assign err_out     = TRAP_VEC;
`else
    assign err_out     = out_q;
`endif

    // Prioritised command decode: call > ret > load > inc > hold
    always_comb begin
        out_d = out_q;
        sp_d  = sp_q;
        ovf_d = ovf_q & ~clr_err_i;
        unf_d = unf_q & ~clr_err_i;
        push  = 1'b0;
        if (call_i) begin
            if (full_o) begin
                ovf_d = 1'b1;
                out_d = err_out;
            end else begin
                push  = 1'b1;
                sp_d  = sp_q + 1'b1;
                out_d = in_i;
            end
        end else if (ret_i) begin
            if (empty_o) begin
                unf_d = 1'b1;
                out_d = err_out;
            end else begin
                sp_d  = sp_q - 1'b1;
                out_d = stack_q[rd_idx];
            end
        end else if (load_i) begin
            out_d = in_i;
        end else if (inc_i) begin
            out_d = ret_addr;
        end
    end

    // Counter, stack pointer and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= RESET_VEC;
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Return-address storage; a push writes the slot just above the top
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
        end else if (push) begin
            stack_q[wr_idx] <= ret_addr;
        end
    end
endmodule
